// File: rtl/dpram_access_scheduler_if.sv
// Request/response channels, RAM-side ports and control/status of the dual-port RAM scheduler.
// The slave modport is the scheduler's view; the master modport is the requesters + RAM view.
interface dpram_access_scheduler_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32,
  parameter int unsigned CW = 16
);
  logic          clearReq;
  logic          initDone;
  logic [CW-1:0] conflictCount;

  logic          aReqValid;
  logic          aReqReady;
  logic          aReqWrite;
  logic [AW-1:0] aReqAddr;
  logic [DW-1:0] aReqWData;
  logic          aRspValid;
  logic [DW-1:0] aRspData;

  logic          bReqValid;
  logic          bReqReady;
  logic          bReqWrite;
  logic [AW-1:0] bReqAddr;
  logic [DW-1:0] bReqWData;
  logic          bRspValid;
  logic [DW-1:0] bRspData;

  logic          ramAEn;
  logic          ramAWrite;
  logic [AW-1:0] ramAAddr;
  logic [DW-1:0] ramAWriteData;
  logic [DW-1:0] ramAReadData;

  logic          ramBEn;
  logic          ramBWrite;
  logic [AW-1:0] ramBAddr;
  logic [DW-1:0] ramBWriteData;
  logic [DW-1:0] ramBReadData;

  modport slave (
    input  clearReq,
    input  aReqValid, aReqWrite, aReqAddr, aReqWData,
    input  bReqValid, bReqWrite, bReqAddr, bReqWData,
    input  ramAReadData, ramBReadData,
    output initDone, conflictCount,
    output aReqReady, aRspValid, aRspData,
    output bReqReady, bRspValid, bRspData,
    output ramAEn, ramAWrite, ramAAddr, ramAWriteData,
    output ramBEn, ramBWrite, ramBAddr, ramBWriteData
  );

  modport master (
    output clearReq,
    output aReqValid, aReqWrite, aReqAddr, aReqWData,
    output bReqValid, bReqWrite, bReqAddr, bReqWData,
    output ramAReadData, ramBReadData,
    input  initDone, conflictCount,
    input  aReqReady, aRspValid, aRspData,
    input  bReqReady, bRspValid, bRspData,
    input  ramAEn, ramAWrite, ramAAddr, ramAWriteData,
    input  ramBEn, ramBWrite, ramBAddr, ramBWriteData
  );
endinterface

// File: rtl/dpram_access_scheduler.sv
// Dual-port RAM front end: per-port request pass-through, round-robin serialisation of
// same-address write collisions, registered read responses and a zero-fill sweep.
module dpram_access_scheduler #(
  parameter int unsigned AW            = 8,
  parameter int unsigned DW            = 32,
  parameter int unsigned CW            = 16,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input logic                     clk,
  input logic                     rstN,
  dpram_access_scheduler_if.slave bus
);

  localparam int unsigned   PW       = (AW > 1) ? AW - 1 : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'((64'd1 << (AW - 1)) - 64'd1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_init_ptr;
  logic [PW-1:0] w_init_ptr_nxt;
  logic          r_rr_b;
  logic          w_rr_b_nxt;
  logic [CW-1:0] r_conflict_cnt;
  logic [CW-1:0] w_conflict_cnt_nxt;
  logic          r_init_done;

  logic          r_a_rsp_valid;
  logic [DW-1:0] r_a_rsp_data;
  logic          r_b_rsp_valid;
  logic [DW-1:0] r_b_rsp_data;

  logic          w_collision;
  logic          w_a_ready;
  logic          w_b_ready;
  logic          w_a_fire;
  logic          w_b_fire;
  logic          w_a_rd_fire;
  logic          w_b_rd_fire;
  logic [AW-1:0] w_init_addr_a;
  logic [AW-1:0] w_init_addr_b;

  logic          w_ram_a_en;
  logic          w_ram_a_write;
  logic [AW-1:0] w_ram_a_addr;
  logic [DW-1:0] w_ram_a_wdata;
  logic          w_ram_b_en;
  logic          w_ram_b_write;
  logic [AW-1:0] w_ram_b_addr;
  logic [DW-1:0] w_ram_b_wdata;

  // Sweep clears an even/odd address pair per cycle, one on each RAM port.
  if (AW > 1) begin : g_pair_addr
    assign w_init_addr_a = {r_init_ptr, 1'b0};
    assign w_init_addr_b = {r_init_ptr, 1'b1};
  end else begin : g_single_addr
    assign w_init_addr_a = 1'b0;
    assign w_init_addr_b = 1'b1;
  end

  assign w_collision = bus.aReqValid & bus.bReqValid &
                       bus.aReqWrite & bus.bReqWrite &
                       (bus.aReqAddr == bus.bReqAddr);

  // Next-state, arbitration and RAM port drive.
  always_comb begin
    w_state_nxt        = r_state;
    w_init_ptr_nxt     = r_init_ptr;
    w_rr_b_nxt         = r_rr_b;
    w_conflict_cnt_nxt = r_conflict_cnt;
    w_a_ready          = 1'b0;
    w_b_ready          = 1'b0;
    w_ram_a_en         = 1'b0;
    w_ram_a_write      = 1'b0;
    w_ram_a_addr       = '0;
    w_ram_a_wdata      = '0;
    w_ram_b_en         = 1'b0;
    w_ram_b_write      = 1'b0;
    w_ram_b_addr       = '0;
    w_ram_b_wdata      = '0;

    unique case (r_state)
      ST_INIT: begin
        w_ram_a_en    = 1'b1;
        w_ram_a_write = 1'b1;
        w_ram_a_addr  = w_init_addr_a;
        w_ram_b_en    = 1'b1;
        w_ram_b_write = 1'b1;
        w_ram_b_addr  = w_init_addr_b;
        if (r_init_ptr == PTR_LAST) begin
          w_state_nxt    = ST_RUN;
          w_init_ptr_nxt = '0;
        end else begin
          w_init_ptr_nxt = r_init_ptr + PW'(1);
        end
      end
      ST_RUN: begin
        if (bus.clearReq) begin
          w_state_nxt    = ST_INIT;
          w_init_ptr_nxt = '0;
        end else if (w_collision) begin
          // Only the favoured channel proceeds; the loser is favoured next time.
          w_a_ready  = ~r_rr_b;
          w_b_ready  = r_rr_b;
          w_rr_b_nxt = ~r_rr_b;
          if (r_conflict_cnt != CNT_MAX) begin
            w_conflict_cnt_nxt = r_conflict_cnt + CW'(1);
          end
        end else begin
          w_a_ready = 1'b1;
          w_b_ready = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase

    w_a_fire = bus.aReqValid & w_a_ready;
    w_b_fire = bus.bReqValid & w_b_ready;

    if (w_a_fire) begin
      w_ram_a_en    = 1'b1;
      w_ram_a_write = bus.aReqWrite;
      w_ram_a_addr  = bus.aReqAddr;
      w_ram_a_wdata = bus.aReqWData;
    end
    if (w_b_fire) begin
      w_ram_b_en    = 1'b1;
      w_ram_b_write = bus.bReqWrite;
      w_ram_b_addr  = bus.bReqAddr;
      w_ram_b_wdata = bus.bReqWData;
    end
  end

  assign w_a_rd_fire = w_a_fire & ~bus.aReqWrite;
  assign w_b_rd_fire = w_b_fire & ~bus.bReqWrite;

  // State, arbitration pointer, counter and read-response registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state        <= INIT_ON_RESET ? ST_INIT : ST_RUN;
      r_init_ptr     <= '0;
      r_rr_b         <= 1'b0;
      r_conflict_cnt <= '0;
      r_init_done    <= ~INIT_ON_RESET;
      r_a_rsp_valid  <= 1'b0;
      r_a_rsp_data   <= '0;
      r_b_rsp_valid  <= 1'b0;
      r_b_rsp_data   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_init_ptr     <= w_init_ptr_nxt;
      r_rr_b         <= w_rr_b_nxt;
      r_conflict_cnt <= w_conflict_cnt_nxt;
      r_init_done    <= (w_state_nxt == ST_RUN);
      r_a_rsp_valid  <= w_a_rd_fire;
      r_b_rsp_valid  <= w_b_rd_fire;
      if (w_a_rd_fire) begin
        r_a_rsp_data <= bus.ramAReadData;
      end
      if (w_b_rd_fire) begin
        r_b_rsp_data <= bus.ramBReadData;
      end
    end
  end

  assign bus.aReqReady     = w_a_ready;
  assign bus.bReqReady     = w_b_ready;
  assign bus.initDone      = r_init_done;
  assign bus.conflictCount = r_conflict_cnt;
  assign bus.aRspValid     = r_a_rsp_valid;
  assign bus.aRspData      = r_a_rsp_data;
  assign bus.bRspValid     = r_b_rsp_valid;
  assign bus.bRspData      = r_b_rsp_data;

  assign bus.ramAEn        = w_ram_a_en;
  assign bus.ramAWrite     = w_ram_a_write;
  assign bus.ramAAddr      = w_ram_a_addr;
  assign bus.ramAWriteData = w_ram_a_wdata;
  assign bus.ramBEn        = w_ram_b_en;
  assign bus.ramBWrite     = w_ram_b_write;
  assign bus.ramBAddr      = w_ram_b_addr;
  assign bus.ramBWriteData = w_ram_b_wdata;

endmodule

// File: tb/tb_dpram_access_scheduler.sv
// Bench for dpram_access_scheduler: an AW=8 instance checked every cycle against a behavioural
// model, and an AW=4/CW=2 instance for sweep length, clear and counter saturation.
module tb_dpram_access_scheduler;

  logic clk = 1'b0;
  logic rst_m;
  logic rst_s;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dpram_access_scheduler_if #(.AW(8), .DW(32), .CW(16)) bus_m ();
  dpram_access_scheduler_if #(.AW(4), .DW(32), .CW(2))  bus_s ();

  dpram_access_scheduler #(.AW(8), .DW(32), .CW(16), .INIT_ON_RESET(1'b1)) u_dut_m (
    .clk (clk),
    .rstN(rst_m),
    .bus (bus_m)
  );

  dpram_access_scheduler #(.AW(4), .DW(32), .CW(2), .INIT_ON_RESET(1'b1)) u_dut_s (
    .clk (clk),
    .rstN(rst_s),
    .bus (bus_s)
  );

  // RAM behind each scheduler: synchronous write, combinational read.
  logic [31:0] ram_m [256];
  logic [31:0] ram_s [16];

  always @(posedge clk) begin
    if (bus_m.ramAEn && bus_m.ramAWrite) ram_m[bus_m.ramAAddr] <= bus_m.ramAWriteData;
    if (bus_m.ramBEn && bus_m.ramBWrite) ram_m[bus_m.ramBAddr] <= bus_m.ramBWriteData;
    if (bus_s.ramAEn && bus_s.ramAWrite) ram_s[bus_s.ramAAddr] <= bus_s.ramAWriteData;
    if (bus_s.ramBEn && bus_s.ramBWrite) ram_s[bus_s.ramBAddr] <= bus_s.ramBWriteData;
  end

  assign bus_m.ramAReadData = ram_m[bus_m.ramAAddr];
  assign bus_m.ramBReadData = ram_m[bus_m.ramBAddr];
  assign bus_s.ramAReadData = ram_s[bus_s.ramAAddr];
  assign bus_s.ramBReadData = ram_s[bus_s.ramBAddr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the AW=8 instance ----------------
  bit          m_valid = 1'b0;
  bit          m_init;
  int          m_k;
  bit          m_fav_b;
  int          m_cnt;
  logic        m_arv, m_brv;
  logic [31:0] m_ard, m_brd;
  logic [31:0] m_mem [256];

  always @(negedge clk) begin : model
    logic        coll, e_ar, e_br, af, bf;
    logic        e_aen, e_awr, e_ben, e_bwr;
    logic [7:0]  e_aa, e_ba;
    logic [31:0] e_ad, e_bd;
    e_ar = 0; e_br = 0; e_aen = 0; e_awr = 0; e_ben = 0; e_bwr = 0;
    e_aa = 0; e_ba = 0; e_ad = 0; e_bd = 0;
    coll = bus_m.aReqValid && bus_m.bReqValid && bus_m.aReqWrite && bus_m.bReqWrite &&
           (bus_m.aReqAddr == bus_m.bReqAddr);
    if (m_init) begin
      e_aen = 1; e_awr = 1; e_aa = 8'(2 * m_k);
      e_ben = 1; e_bwr = 1; e_ba = 8'(2 * m_k + 1);
    end else if (!bus_m.clearReq) begin
      e_ar = coll ? !m_fav_b : 1'b1;
      e_br = coll ?  m_fav_b : 1'b1;
    end
    af = e_ar && bus_m.aReqValid;
    bf = e_br && bus_m.bReqValid;
    if (af) begin e_aen = 1; e_awr = bus_m.aReqWrite; e_aa = bus_m.aReqAddr; e_ad = bus_m.aReqWData; end
    if (bf) begin e_ben = 1; e_bwr = bus_m.bReqWrite; e_ba = bus_m.bReqAddr; e_bd = bus_m.bReqWData; end

    if (m_valid) begin
      chk("m_ready",    {bus_m.aReqReady, bus_m.bReqReady}, {e_ar, e_br});
      chk("m_ramA",     {bus_m.ramAEn, bus_m.ramAWrite, bus_m.ramAAddr, bus_m.ramAWriteData},
                        {e_aen, e_awr, e_aa, e_ad});
      chk("m_ramB",     {bus_m.ramBEn, bus_m.ramBWrite, bus_m.ramBAddr, bus_m.ramBWriteData},
                        {e_ben, e_bwr, e_ba, e_bd});
      chk("m_initDone", bus_m.initDone, !m_init);
      chk("m_count",    bus_m.conflictCount, m_cnt);
      chk("m_rspA",     {bus_m.aRspValid, bus_m.aRspData}, {m_arv, m_ard});
      chk("m_rspB",     {bus_m.bRspValid, bus_m.bRspData}, {m_brv, m_brd});
    end

    if (!rst_m) begin
      m_valid = 1; m_init = 1; m_k = 0; m_fav_b = 0; m_cnt = 0;
      m_arv = 0; m_brv = 0; m_ard = 0; m_brd = 0;
    end else if (m_valid && m_init) begin
      m_mem[2 * m_k] = 0;
      m_mem[2 * m_k + 1] = 0;
      m_arv = 0; m_brv = 0;
      if (m_k == 127) begin m_init = 0; m_k = 0; end
      else m_k++;
    end else if (m_valid) begin
      // Reads see the memory as it was before this cycle's writes.
      m_arv = af && !bus_m.aReqWrite;
      m_brv = bf && !bus_m.bReqWrite;
      if (m_arv) m_ard = m_mem[bus_m.aReqAddr];
      if (m_brv) m_brd = m_mem[bus_m.bReqAddr];
      if (af && bus_m.aReqWrite) m_mem[bus_m.aReqAddr] = bus_m.aReqWData;
      if (bf && bus_m.bReqWrite) m_mem[bus_m.bReqAddr] = bus_m.bReqWData;
      if (coll && !bus_m.clearReq) begin
        m_fav_b = !m_fav_b;
        if (m_cnt < 65535) m_cnt++;
      end
      if (bus_m.clearReq) begin m_init = 1; m_k = 0; end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus_m.aReqValid = v; bus_m.aReqWrite = w; bus_m.aReqAddr = a; bus_m.aReqWData = d;
  endtask

  task automatic drive_b(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    bus_m.bReqValid = v; bus_m.bReqWrite = w; bus_m.bReqAddr = a; bus_m.bReqWData = d;
  endtask

  task automatic idle_m();
    drive_a(0, 0, 8'h00, 32'h0);
    drive_b(0, 0, 8'h00, 32'h0);
  endtask

  task automatic drive_s(input logic av, input logic aw, input logic [3:0] aa, input logic [31:0] ad,
                         input logic bv, input logic bw, input logic [3:0] ba, input logic [31:0] bd);
    bus_s.aReqValid = av; bus_s.aReqWrite = aw; bus_s.aReqAddr = aa; bus_s.aReqWData = ad;
    bus_s.bReqValid = bv; bus_s.bReqWrite = bw; bus_s.bReqAddr = ba; bus_s.bReqWData = bd;
  endtask

  task automatic wait_init_m(output int n);
    n = 0;
    while (!bus_m.initDone && n < 400) begin cyc(); n++; end
  endtask

  task automatic wait_init_s(output int n);
    n = 0;
    while (!bus_s.initDone && n < 100) begin cyc(); n++; end
  endtask

  initial begin
    int n;
    rst_m = 0; rst_s = 0;
    bus_m.clearReq = 0; bus_s.clearReq = 0;
    idle_m();
    drive_s(0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    cyc(); cyc();
    chk("reset_initDone", bus_m.initDone, 0);
    chk("reset_count", bus_m.conflictCount, 0);
    chk("reset_rsp", {bus_m.aRspValid, bus_m.aRspData, bus_m.bRspValid, bus_m.bRspData}, 0);
    rst_m = 1;
    wait_init_m(n);
    chk("sweep_len_aw8", n, 128);

    // Write on A, read it back on B the next cycle.
    drive_a(1, 1, 8'h05, 32'hDEADBEEF);
    cyc();
    drive_a(0, 0, 8'h00, 0);
    drive_b(1, 0, 8'h05, 0);
    cyc();
    idle_m();
    chk("wr_rd_rsp", {bus_m.bRspValid, bus_m.bRspData}, {1'b1, 32'hDEADBEEF});
    cyc();
    chk("rsp_pulse", bus_m.bRspValid, 0);

    // Four back-to-back colliding writes alternate grants A,B,A,B.
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 1, 8'h30, 32'hA000 + i);
      drive_b(1, 1, 8'h30, 32'hB000 + i);
      #1;
      chk("rr_grant", {bus_m.aReqReady, bus_m.bReqReady}, (i % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    idle_m();
    chk("count_after_4", bus_m.conflictCount, 4);
    drive_a(1, 0, 8'h30, 0);
    cyc();
    idle_m();
    chk("rr_last_write", bus_m.aRspData, 32'hB003);

    // Single collision: A wins, B follows next cycle and its data lands last.
    drive_a(1, 1, 8'h10, 32'h1111);
    drive_b(1, 1, 8'h10, 32'h2222);
    #1;
    chk("coll_ready", {bus_m.aReqReady, bus_m.bReqReady}, 2'b10);
    cyc();
    drive_a(0, 0, 8'h00, 0);
    #1;
    chk("loser_ready", bus_m.bReqReady, 1);
    cyc();
    idle_m();
    chk("count_after_5", bus_m.conflictCount, 5);
    drive_a(1, 0, 8'h10, 0);
    cyc();
    idle_m();
    chk("coll_final", {bus_m.aRspValid, bus_m.aRspData}, {1'b1, 32'h2222});

    // Read and write of one address on different ports: read sees old data.
    drive_a(1, 1, 8'h20, 32'h1234);
    drive_b(1, 0, 8'h20, 0);
    cyc();
    idle_m();
    chk("rd_old_data", {bus_m.bRspValid, bus_m.bRspData}, {1'b1, 32'h0});
    drive_b(1, 0, 8'h20, 0);
    cyc();
    idle_m();
    chk("rd_new_data", bus_m.bRspData, 32'h1234);

    // Mixed traffic on a small address window, checked by the model.
    for (int i = 0; i < 60; i++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(64, 67)), $urandom);
      drive_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(64, 67)), $urandom);
      cyc();
    end
    idle_m();

    // Clear on demand restarts the sweep.
    bus_m.clearReq = 1;
    drive_a(1, 0, 8'h10, 0);
    #1;
    chk("clear_blocks", {bus_m.aReqReady, bus_m.bReqReady}, 2'b00);
    cyc();
    bus_m.clearReq = 0;
    chk("clear_initDone", bus_m.initDone, 0);
    wait_init_m(n);
    chk("clear_sweep_aw8", n, 128);
    cyc();
    idle_m();
    chk("clear_zeroed", {bus_m.aRspValid, bus_m.aRspData}, {1'b1, 32'h0});

    // ---------------- AW=4, CW=2 instance ----------------
    rst_s = 1;
    wait_init_s(n);
    chk("sweep_len_aw4", n, 8);
    for (int i = 0; i < 16; i++) begin
      drive_s(1, 0, 4'(i), 0, 0, 0, 4'h0, 0);
      cyc();
      chk("s_init_zero", {bus_s.aRspValid, bus_s.aRspData}, {1'b1, 32'h0});
    end
    drive_s(1, 1, 4'h3, 32'h55, 1, 1, 4'h9, 32'h66);
    cyc();
    drive_s(1, 0, 4'h3, 0, 1, 0, 4'h9, 0);
    cyc();
    chk("s_readback", {bus_s.aRspData, bus_s.bRspData}, {32'h55, 32'h66});

    bus_s.clearReq = 1;
    drive_s(1, 0, 4'h3, 0, 0, 0, 4'h0, 0);
    #1;
    chk("s_clear_ready", bus_s.aReqReady, 0);
    cyc();
    bus_s.clearReq = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("s_sweep_ready", {bus_s.aReqReady, bus_s.initDone}, 2'b00);
      cyc();
    end
    #1;
    chk("s_ready_back", {bus_s.aReqReady, bus_s.initDone}, 2'b11);
    cyc();
    chk("s_cleared", {bus_s.aRspValid, bus_s.aRspData}, {1'b1, 32'h0});

    drive_s(1, 1, 4'h1, 32'h7, 1, 1, 4'h1, 32'h8);
    for (int i = 0; i < 5; i++) cyc();
    drive_s(0, 0, 4'h0, 0, 0, 0, 4'h0, 0);
    chk("s_count_sat", bus_s.conflictCount, 3);

    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
